// File: rtl/data_mem_io_if.sv
// Datapath memory-port and TX-stream bundle for data_mem_io.
// The slave side is the memory subsystem; the master side is the datapath plus the TX consumer.
interface data_mem_io_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] dataAddress;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  WE;
  logic [DATA_WIDTH-1:0] readData;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output dataAddress, writeData, WE, tx_ready,
    input  readData, tx_data, tx_valid
  );

  modport slave (
    input  dataAddress, writeData, WE, tx_ready,
    output readData, tx_data, tx_valid
  );
endinterface

// File: rtl/data_mem_io.sv
// Data RAM with a 16-word MMIO window (GPIO, TX FIFO, timer) for the 16-bit CPU.
// Timer registers, MATCH and timer_irq are only built when DATA_MEM_IO_TIMER_EN is defined.
module data_mem_io #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    FIFO_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 10'h200
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_io_if.slave          bus,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic                  timer_irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [3:0] IDX_GPIO_OUT = 4'h0;
  localparam logic [3:0] IDX_GPIO_IN  = 4'h1;
  localparam logic [3:0] IDX_TX_DATA  = 4'h2;
  localparam logic [3:0] IDX_STATUS   = 4'h3;
  localparam logic [3:0] IDX_T_COUNT  = 4'h4;
  localparam logic [3:0] IDX_T_CTRL   = 4'h5;
  localparam logic [3:0] IDX_T_CMP    = 4'h6;

  function automatic logic [DATA_WIDTH-1:0] pack_status(
    input logic       empty,
    input logic       full,
    input logic       ovf,
    input logic       match,
    input logic [3:0] cnt
  );
    pack_status = DATA_WIDTH'({cnt, match, ovf, full, empty});
  endfunction

  // Address decode
  logic       mmio_hit;
  logic [3:0] reg_idx;
  logic       wr_mmio;
  logic       wr_gpio;
  logic       wr_status;

  assign mmio_hit  = (bus.dataAddress[ADDR_WIDTH-1:4] == MMIO_BASE[ADDR_WIDTH-1:4]);
  assign reg_idx   = bus.dataAddress[3:0];
  assign wr_mmio   = bus.WE & mmio_hit;
  assign wr_gpio   = wr_mmio & (reg_idx == IDX_GPIO_OUT);
  assign wr_status = wr_mmio & (reg_idx == IDX_STATUS);

  // Data RAM: words shadowed by the MMIO window are never written
  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
  logic                  ram_we;

  assign ram_we = bus.WE & ~mmio_hit;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[bus.dataAddress] <= bus.writeData;
    end
  end

  // GPIO output register and two-flop input synchronizer
  logic [DATA_WIDTH-1:0] gpio_out_q, gpio_out_d;
  logic [DATA_WIDTH-1:0] gpio_meta_q, gpio_meta_d;
  logic [DATA_WIDTH-1:0] gpio_sync_q, gpio_sync_d;

  always_comb begin
    gpio_out_d  = gpio_out_q;
    gpio_meta_d = gpio_in;
    gpio_sync_d = gpio_meta_q;
    if (wr_gpio) begin
      gpio_out_d = bus.writeData;
    end
  end

  assign gpio_out = gpio_out_q;

  // TX FIFO
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  push_req;
  logic                  push;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = ~fifo_empty & bus.tx_ready;
  assign push_req   = wr_mmio & (reg_idx == IDX_TX_DATA);
  // A pop in the same cycle frees the slot, so a push at full still lands
  assign push       = push_req & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.writeData;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (wr_status & bus.writeData[2]) begin
      ovf_d = 1'b0;
    end
    if (push_req & ~push) begin
      ovf_d = 1'b1;
    end
  end

  assign bus.tx_valid = ~fifo_empty;
  assign bus.tx_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_q];

  // Timer
  logic                  match_flag;
  logic [DATA_WIDTH-1:0] tcount_rd;
  logic [DATA_WIDTH-1:0] tctrl_rd;
  logic [DATA_WIDTH-1:0] tcmp_rd;

`ifdef DATA_MEM_IO_TIMER_EN
  logic [DATA_WIDTH-1:0] tcount_q, tcount_d;
  logic [DATA_WIDTH-1:0] tcmp_q, tcmp_d;
  logic [1:0]            tctrl_q, tctrl_d;
  logic                  match_q, match_d;
  logic                  tmr_hit;
  logic                  wr_tcount;
  logic                  wr_tctrl;
  logic                  wr_tcmp;

  assign wr_tcount = wr_mmio & (reg_idx == IDX_T_COUNT);
  assign wr_tctrl  = wr_mmio & (reg_idx == IDX_T_CTRL);
  assign wr_tcmp   = wr_mmio & (reg_idx == IDX_T_CMP);
  assign tmr_hit   = tctrl_q[0] & (tcount_q == tcmp_q);

  always_comb begin
    tcount_d = tcount_q;
    tcmp_d   = tcmp_q;
    tctrl_d  = tctrl_q;
    match_d  = match_q;
    if (tmr_hit) begin
      tcount_d = '0;
    end else if (tctrl_q[0]) begin
      tcount_d = tcount_q + DATA_WIDTH'(1);
    end
    // CPU write to COUNT wins over increment/clear; MATCH set wins over W1C
    if (wr_tcount) begin
      tcount_d = bus.writeData;
    end
    if (wr_tctrl) begin
      tctrl_d = bus.writeData[1:0];
    end
    if (wr_tcmp) begin
      tcmp_d = bus.writeData;
    end
    if (wr_status & bus.writeData[3]) begin
      match_d = 1'b0;
    end
    if (tmr_hit) begin
      match_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcount_q <= '0;
      tcmp_q   <= '1;
      tctrl_q  <= '0;
      match_q  <= 1'b0;
    end else begin
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      tctrl_q  <= tctrl_d;
      match_q  <= match_d;
    end
  end

  assign match_flag = match_q;
  assign tcount_rd  = tcount_q;
  assign tctrl_rd   = DATA_WIDTH'(tctrl_q);
  assign tcmp_rd    = tcmp_q;
  assign timer_irq  = match_q & tctrl_q[1];
`else
  assign match_flag = 1'b0;
  assign tcount_rd  = '0;
  assign tctrl_rd   = '0;
  assign tcmp_rd    = '0;
  assign timer_irq  = 1'b0;
`endif

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out_q  <= '0;
      gpio_meta_q <= '0;
      gpio_sync_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      gpio_out_q  <= gpio_out_d;
      gpio_meta_q <= gpio_meta_d;
      gpio_sync_q <= gpio_sync_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  // Side-effect-free read path, valid in the same cycle as dataAddress
  logic [DATA_WIDTH-1:0] mmio_rdata;

  always_comb begin
    mmio_rdata = '0;
    case (reg_idx)
      IDX_GPIO_OUT: mmio_rdata = gpio_out_q;
      IDX_GPIO_IN:  mmio_rdata = gpio_sync_q;
      IDX_STATUS:   mmio_rdata = pack_status(fifo_empty, fifo_full, ovf_q, match_flag, 4'(count_q));
      IDX_T_COUNT:  mmio_rdata = tcount_rd;
      IDX_T_CTRL:   mmio_rdata = tctrl_rd;
      IDX_T_CMP:    mmio_rdata = tcmp_rd;
      default:      mmio_rdata = '0;
    endcase
  end

  assign bus.readData = mmio_hit ? mmio_rdata : ram[bus.dataAddress];

endmodule

// File: tb/tb_data_mem_io.sv
// Self-checking bench for data_mem_io: directed vector table, multi-cycle sequences,
// and a randomized run against a queue/array reference model.
module tb_data_mem_io;
  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
`ifdef DATA_MEM_IO_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] gpio_in = '0;
  logic [DW-1:0] gpio_out;
  logic          timer_irq;

  data_mem_io_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  data_mem_io #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MMIO_BASE(10'h200)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after the write edge.
  task automatic wr(input logic [9:0] a, input logic [15:0] d);
    bus.dataAddress = a;
    bus.writeData   = d;
    bus.WE          = 1'b1;
    @(negedge clk);
    bus.WE = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, output logic [15:0] d);
    bus.dataAddress = a;
    bus.WE          = 1'b0;
    #1;
    d = bus.readData;
  endtask

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vt[12];

  // Reference model state for the randomized run
  logic [15:0] ram_m [1024];
  bit          known [1024];
  logic [15:0] fq [$];
  logic [15:0] gm, g1, g2, tcnt, tcmp;
  logic [1:0]  tctrl;
  logic        ovf_m, match_m;

  function automatic logic [15:0] status_m();
    logic [3:0] c;
    c = 4'(fq.size());
    return {8'h00, c, (TIMER ? match_m : 1'b0), ovf_m, (fq.size() == DEPTH), (fq.size() == 0)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic [15:0] shadow;
    logic [15:0] last;
    int          got;

    bus.dataAddress = '0;
    bus.writeData   = '0;
    bus.WE          = 1'b0;
    bus.tx_ready    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_gpio_out", gpio_out, 16'h0000);
    check("rst_tx_valid", 16'(bus.tx_valid), 16'h0000);
    check("rst_tx_data", bus.tx_data, 16'h0000);
    check("rst_timer_irq", 16'(timer_irq), 16'h0000);
    rd(10'h203, r);
    check("rst_status", r, 16'h0001);
    rd(10'h206, r);
    check("rst_cmp", r, TIMER ? 16'hFFFF : 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    // Directed vector table
    vt[0]  = '{1'b1, 10'h3FE, 16'hBEEF, 16'hBEEF, "ram_wr_rd"};
    vt[1]  = '{1'b1, 10'h200, 16'h1234, 16'h1234, "gpio_out_rd"};
    vt[2]  = '{1'b1, 10'h001, 16'h5555, 16'h5555, "ram_low"};
    vt[3]  = '{1'b0, 10'h3FE, 16'h0000, 16'hBEEF, "ram_hold"};
    vt[4]  = '{1'b1, 10'h202, 16'h00AA, 16'h0000, "tx_data_reads0"};
    vt[5]  = '{1'b0, 10'h203, 16'h0000, 16'h0010, "status_cnt1"};
    vt[6]  = '{1'b1, 10'h207, 16'hFFFF, 16'h0000, "unmapped_7"};
    vt[7]  = '{1'b1, 10'h20F, 16'h1111, 16'h0000, "unmapped_f"};
    vt[8]  = '{1'b1, 10'h206, 16'h0042, (TIMER ? 16'h0042 : 16'h0000), "timer_cmp"};
    vt[9]  = '{1'b1, 10'h205, 16'h00FE, (TIMER ? 16'h0002 : 16'h0000), "timer_ctrl_mask"};
    vt[10] = '{1'b1, 10'h204, 16'h0007, (TIMER ? 16'h0007 : 16'h0000), "timer_count_hold"};
    vt[11] = '{1'b1, 10'h201, 16'hFFFF, 16'h0000, "gpio_in_ro"};

    shadow = dut.ram[10'h200];
    for (int i = 0; i < 12; i++) begin
      if (vt[i].we) wr(vt[i].addr, vt[i].wdata);
      rd(vt[i].addr, r);
      check(vt[i].name, r, vt[i].exp);
      @(negedge clk);
    end
    check("gpio_out_port", gpio_out, 16'h1234);
    check("ram_shadow_200", dut.ram[10'h200], shadow);
    check("tx_valid_one", 16'(bus.tx_valid), 16'h0001);
    check("tx_data_head", bus.tx_data, 16'h00AA);
    check("timer_irq_no_match", 16'(timer_irq), 16'h0000);

    // GPIO_IN two-cycle synchronizer latency
    gpio_in = 16'hA5A5;
    rd(10'h201, r);
    check("gpio_in_lat0", r, 16'h0000);
    @(negedge clk);
    rd(10'h201, r);
    check("gpio_in_lat1", r, 16'h0000);
    @(negedge clk);
    rd(10'h201, r);
    check("gpio_in_lat2", r, 16'hA5A5);
    @(negedge clk);

    // Drain the single entry
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    #1;
    check("drain_one_valid", 16'(bus.tx_valid), 16'h0000);
    @(negedge clk);

    // FIFO fill to overflow, then drain in order
    for (int v = 1; v <= 9; v++) wr(10'h202, 16'(v));
    rd(10'h203, r);
    check("fill_status", r, 16'h0086);
    check("fill_head", bus.tx_data, 16'h0001);
    @(negedge clk);
    bus.tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      check($sformatf("drain_valid[%0d]", i), 16'(bus.tx_valid), 16'h0001);
      check($sformatf("drain_data[%0d]", i), bus.tx_data, 16'(i));
      @(negedge clk);
    end
    #1;
    check("drain_empty_valid", 16'(bus.tx_valid), 16'h0000);
    check("drain_empty_data", bus.tx_data, 16'h0000);
    bus.tx_ready = 1'b0;
    wr(10'h203, 16'h0004);
    rd(10'h203, r);
    check("ovf_w1c", r, 16'h0001);
    @(negedge clk);

    // Full FIFO with simultaneous push and pop
    for (int v = 0; v < 8; v++) wr(10'h202, 16'h0010 + 16'(v));
    rd(10'h203, r);
    check("full_status", r, 16'h0082);
    @(negedge clk);
    bus.dataAddress = 10'h202;
    bus.writeData   = 16'h0099;
    bus.WE          = 1'b1;
    bus.tx_ready    = 1'b1;
    @(negedge clk);
    bus.WE       = 1'b0;
    bus.tx_ready = 1'b0;
    rd(10'h203, r);
    check("pushpop_full_status", r, 16'h0082);
    check("pushpop_head", bus.tx_data, 16'h0011);
    bus.tx_ready = 1'b1;
    got  = 0;
    last = '0;
    for (int c = 0; c < 20 && bus.tx_valid; c++) begin
      last = bus.tx_data;
      got++;
      @(negedge clk);
      #1;
    end
    bus.tx_ready = 1'b0;
    check("pushpop_drain_count", 16'(got), 16'd8);
    check("pushpop_tail", last, 16'h0099);
    check("pushpop_empty", 16'(bus.tx_valid), 16'h0000);
    @(negedge clk);

    // Timer
`ifdef DATA_MEM_IO_TIMER_EN
    begin
      logic [15:0] exp_cnt [5];
      exp_cnt = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
      wr(10'h206, 16'd3);
      wr(10'h204, 16'd0);
      wr(10'h205, 16'd3);
      for (int k = 0; k < 5; k++) begin
        rd(10'h204, r);
        check($sformatf("tmr_count[%0d]", k), r, exp_cnt[k]);
        check($sformatf("tmr_irq[%0d]", k), 16'(timer_irq), (k == 4) ? 16'd1 : 16'd0);
        if (k == 4) begin
          rd(10'h203, r);
          check("tmr_match_bit", r & 16'h0008, 16'h0008);
        end
        @(negedge clk);
      end
      wr(10'h205, 16'd0);
      wr(10'h203, 16'h0008);
      rd(10'h203, r);
      check("tmr_w1c_status", r & 16'h0008, 16'h0000);
      check("tmr_w1c_irq", 16'(timer_irq), 16'h0000);
      rd(10'h204, r);
      check("tmr_stopped", r, 16'd2);
      @(negedge clk);
      wr(10'h204, 16'd3);
      wr(10'h205, 16'd1);
      wr(10'h203, 16'h0008);
      rd(10'h203, r);
      check("tmr_set_beats_w1c", r & 16'h0008, 16'h0008);
      check("tmr_irq_masked", 16'(timer_irq), 16'h0000);
      rd(10'h204, r);
      check("tmr_match_clear", r, 16'd0);
      @(negedge clk);
      wr(10'h205, 16'd0);
      wr(10'h203, 16'h0008);
    end
`else
    wr(10'h204, 16'h0005);
    wr(10'h205, 16'h0003);
    wr(10'h206, 16'h0001);
    rd(10'h204, r);
    check("notmr_count", r, 16'h0000);
    rd(10'h205, r);
    check("notmr_ctrl", r, 16'h0000);
    rd(10'h206, r);
    check("notmr_cmp", r, 16'h0000);
    rd(10'h203, r);
    check("notmr_status", r, 16'h0001);
    check("notmr_irq", 16'(timer_irq), 16'h0000);
    @(negedge clk);
`endif

    // Asynchronous reset mid-operation
    wr(10'h200, 16'hABCD);
    for (int v = 0; v < 4; v++) wr(10'h202, 16'h0040 + 16'(v));
    #1;
    check("pre_rst_valid", 16'(bus.tx_valid), 16'h0001);
    check("pre_rst_gpio", gpio_out, 16'hABCD);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 16'(bus.tx_valid), 16'h0000);
    check("async_rst_data", bus.tx_data, 16'h0000);
    check("async_rst_gpio", gpio_out, 16'h0000);
    rd(10'h203, r);
    check("async_rst_status", r, 16'h0001);
    bus.WE = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_held_valid", 16'(bus.tx_valid), 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    // Randomized run against the reference model
    gm = '0; g1 = '0; g2 = '0; tcnt = '0; tcmp = 16'hFFFF; tctrl = '0;
    ovf_m = 1'b0; match_m = 1'b0;
    fq.delete();
    for (int n = 0; n < 600; n++) begin
      logic [9:0]  a;
      logic [3:0]  idx;
      logic [15:0] wd, exp_rd;
      logic        we, mm, rdy, pop, hit, chk;
      mm  = ($urandom_range(0, 9) < 7);
      idx = 4'($urandom_range(0, 15));
      if (mm && $urandom_range(0, 1) == 1) idx = 4'($urandom_range(0, 6));
      a   = mm ? (10'h200 + 10'(idx)) : (10'h3F0 + 10'($urandom_range(0, 15)));
      we  = $urandom_range(0, 1) == 1;
      wd  = 16'($urandom);
      if (mm && (idx == 4'h4 || idx == 4'h6)) wd = 16'($urandom_range(0, 12));
      rdy = ($urandom_range(0, 9) < ((n < 300) ? 3 : 7));
      if ($urandom_range(0, 7) == 0) gpio_in = 16'($urandom);
      bus.dataAddress = a;
      bus.writeData   = wd;
      bus.WE          = we;
      bus.tx_ready    = rdy;
      #1;
      chk    = 1'b1;
      exp_rd = '0;
      if (mm) begin
        case (idx)
          4'h0: exp_rd = gm;
          4'h1: exp_rd = g2;
          4'h3: exp_rd = status_m();
          4'h4: exp_rd = TIMER ? tcnt : 16'h0;
          4'h5: exp_rd = TIMER ? {14'h0, tctrl} : 16'h0;
          4'h6: exp_rd = TIMER ? tcmp : 16'h0;
          default: exp_rd = '0;
        endcase
      end else begin
        chk    = known[a];
        exp_rd = ram_m[a];
      end
      if (chk) check($sformatf("rnd_rd[%0d]", n), bus.readData, exp_rd);
      check($sformatf("rnd_valid[%0d]", n), 16'(bus.tx_valid), 16'(fq.size() != 0));
      check($sformatf("rnd_txdata[%0d]", n), bus.tx_data, (fq.size() != 0) ? fq[0] : 16'h0);
      check($sformatf("rnd_gpio[%0d]", n), gpio_out, gm);
      check($sformatf("rnd_irq[%0d]", n), 16'(timer_irq), 16'(TIMER & match_m & tctrl[1]));

      pop = (fq.size() != 0) && rdy;
      hit = tctrl[0] && (tcnt == tcmp);
      if (pop) void'(fq.pop_front());
      if (we && mm && idx == 4'h3 && wd[2]) ovf_m = 1'b0;
      if (we && mm && idx == 4'h2) begin
        if (fq.size() < DEPTH) fq.push_back(wd);
        else ovf_m = 1'b1;
      end
      if (we && mm && idx == 4'h3 && wd[3]) match_m = 1'b0;
      if (hit) match_m = 1'b1;
      if (hit) tcnt = 16'h0;
      else if (tctrl[0]) tcnt = tcnt + 16'h1;
      if (we && mm && idx == 4'h4) tcnt = wd;
      if (we && mm && idx == 4'h5) tctrl = wd[1:0];
      if (we && mm && idx == 4'h6) tcmp = wd;
      if (we && mm && idx == 4'h0) gm = wd;
      if (we && !mm) begin
        ram_m[a] = wd;
        known[a] = 1'b1;
      end
      g2 = g1;
      g1 = gpio_in;
      @(negedge clk);
    end
    bus.WE = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
